// File: rtl/piano_pkg.sv
// Shared types and widths for the piano note sequencer and its character buffer.
`timescale 1ns/1ps
package piano_pkg;

    localparam int unsigned TONE_W  = 24;
    localparam int unsigned ASCII_W = 8;

    localparam logic [TONE_W-1:0] UNMAPPED_PERIOD = '0;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        PLAY,
        GAP
    } seq_state_e;

endpackage

// File: rtl/piano_char_fifo.sv
// Character buffer between the UART handshake and the note FSM.
// PIANO_NOTE_FIFO_EN selects a DEPTH-entry circular FIFO; otherwise a single holding register.
`timescale 1ns/1ps
module piano_char_fifo
    import piano_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [ASCII_W-1:0]         data_i,
    input  logic                       pop_i,
    output logic [ASCII_W-1:0]         head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

`ifdef PIANO_NOTE_FIFO_EN
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ASCII_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Simultaneous push and pop leave the occupancy unchanged.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
`else
    logic [ASCII_W-1:0] data_q;
    logic               valid_q;
    logic               valid_d;
    logic               do_push;

    assign full_o  = valid_q;
    assign empty_o = !valid_q;
    assign head_o  = data_q;
    assign count_o = CNT_W'(valid_q);
    assign do_push = push_i && !valid_q;
    assign valid_d = do_push || (valid_q && !pop_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (do_push) begin
                data_q <= data_i;
            end
        end
    end
`endif

endmodule

// File: rtl/piano_note_sequencer.sv
// Buffers UART key characters, looks them up in the external scale ROM and plays
// each mapped key as a fixed-length tone followed by a silent gap. Buffer style set by PIANO_NOTE_FIFO_EN.
`timescale 1ns/1ps
module piano_note_sequencer
    import piano_pkg::*;
#(
    parameter int unsigned NOTE_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_250_000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ASCII_W-1:0] ascii_data,
    input  logic               ascii_valid,
    output logic               ascii_ready,
    output logic [ASCII_W-1:0] rom_address,
    input  logic [TONE_W-1:0]  rom_data,
    output logic [TONE_W-1:0]  tone_period,
    output logic               note_active,
    output logic               busy
);

    localparam int unsigned MAX_CYC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned BCNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    seq_state_e         state_q;
    logic [TONE_W-1:0]  tone_q;
    logic               active_q;
    logic [ASCII_W-1:0] addr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               buf_push;
    logic               buf_pop;
    logic               buf_full;
    logic               buf_empty;
    logic [ASCII_W-1:0] buf_head;
    logic [BCNT_W-1:0]  buf_count;

    assign ascii_ready = !buf_full;
    assign buf_push    = ascii_valid && ascii_ready;
    assign buf_pop     = (state_q == IDLE) && !buf_empty;

    piano_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (buf_push),
        .data_i  (ascii_data),
        .pop_i   (buf_pop),
        .head_o  (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    // Note sequencing: pop, look up, hold the tone, then stay silent for the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tone_q   <= UNMAPPED_PERIOD;
            active_q <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!buf_empty) begin
                        addr_q  <= buf_head;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (rom_data == UNMAPPED_PERIOD) begin
                        state_q <= IDLE;
                    end else begin
                        tone_q   <= rom_data;
                        active_q <= 1'b1;
                        cnt_q    <= NOTE_LOAD;
                        state_q  <= PLAY;
                    end
                end
                PLAY: begin
                    if (cnt_q == '0) begin
                        tone_q   <= UNMAPPED_PERIOD;
                        active_q <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= GAP_LOAD;
                            state_q <= GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_address = addr_q;
    assign tone_period = tone_q;
    assign note_active = active_q;
    assign busy        = (buf_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_piano_note_sequencer.sv
// Bench for piano_note_sequencer: two instances (gap 2 and gap 0) against a schedule-based model.
`timescale 1ns/1ps
module tb_piano_note_sequencer;

    localparam int unsigned NOTE_N = 4;
`ifdef PIANO_NOTE_FIFO_EN
    localparam int unsigned BUF_N = 8;
`else
    localparam int unsigned BUF_N = 1;
`endif
    localparam int ACC_FULL = BUF_N + 1;

    typedef struct packed {
        logic [23:0] tone;
        logic        act;
        logic        eng;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_s  [2];
    logic        valid_s [2];
    logic        ready_w [2];
    logic [7:0]  addr_w  [2];
    logic [23:0] rom_w   [2];
    logic [23:0] tone_w  [2];
    logic        active_w[2];
    logic        busy_w  [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ent_t        sched[2][$];
    logic [7:0]  bufq [2][$];
    ent_t        cur  [2];
    logic [7:0]  exp_addr[2];
    logic [23:0] played[$];
    logic [23:0] prev_tone = 24'd0;

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_lookup(input logic [7:0] a);
        case (a)
            8'h43:   return 24'd758432;
            8'h44:   return 24'd675676;
            8'h45:   return 24'd601958;
            8'h46:   return 24'd568182;
            8'h47:   return 24'd506155;
            8'h7A:   return 24'd477781;
            default: return 24'd0;
        endcase
    endfunction

    assign rom_w[0] = rom_lookup(addr_w[0]);
    assign rom_w[1] = rom_lookup(addr_w[1]);

    piano_note_sequencer #(.NOTE_CYCLES(NOTE_N), .GAP_CYCLES(2), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .ascii_data(data_s[0]), .ascii_valid(valid_s[0]), .ascii_ready(ready_w[0]),
        .rom_address(addr_w[0]), .rom_data(rom_w[0]),
        .tone_period(tone_w[0]), .note_active(active_w[0]), .busy(busy_w[0])
    );

    piano_note_sequencer #(.NOTE_CYCLES(NOTE_N), .GAP_CYCLES(0), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .ascii_data(data_s[1]), .ascii_valid(valid_s[1]), .ascii_ready(ready_w[1]),
        .rom_address(addr_w[1]), .rom_data(rom_w[1]),
        .tone_period(tone_w[1]), .note_active(active_w[1]), .busy(busy_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            sched[d].delete();
            bufq[d].delete();
            cur[d] = '0;
            exp_addr[d] = 8'd0;
        end
    endtask

    // One clock edge of the model: the engine either consumes its planned cycle or starts a new key.
    task automatic model_step(input int d);
        ent_t        e;
        logic [7:0]  c;
        logic [23:0] p;
        e = '0;
        if (sched[d].size() != 0) begin
            e = sched[d].pop_front();
        end else if (bufq[d].size() != 0) begin
            c = bufq[d].pop_front();
            exp_addr[d] = c;
            e = '{tone: 24'd0, act: 1'b0, eng: 1'b1};
            p = rom_lookup(c);
            if (p != 24'd0) begin
                for (int i = 0; i < NOTE_N; i++) sched[d].push_back('{tone: p, act: 1'b1, eng: 1'b1});
                for (int i = 0; i < gap_of(d); i++) sched[d].push_back('{tone: 24'd0, act: 1'b0, eng: 1'b1});
            end
            sched[d].push_back('{tone: 24'd0, act: 1'b0, eng: 1'b0});
        end
        if (valid_s[d] && ready_w[d]) bufq[d].push_back(data_s[d]);
        cur[d] = e;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison of both instances against the model, plus a note-start recorder.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("tone[%0d]", d), 32'(tone_w[d]), 32'(cur[d].tone));
                chk($sformatf("active[%0d]", d), 32'(active_w[d]), 32'(cur[d].act));
                chk($sformatf("busy[%0d]", d), 32'(busy_w[d]),
                    32'(cur[d].eng || (bufq[d].size() != 0)));
                chk($sformatf("ready[%0d]", d), 32'(ready_w[d]), 32'(bufq[d].size() < BUF_N));
                chk($sformatf("addr[%0d]", d), 32'(addr_w[d]), 32'(exp_addr[d]));
            end
            if (tone_w[0] != 24'd0 && prev_tone == 24'd0) played.push_back(tone_w[0]);
            prev_tone = tone_w[0];
        end
    end

    task automatic send(input int d, input logic [7:0] c, output int acc);
        logic took;
        int   n;
        took = 1'b0;
        n = 0;
        data_s[d] = c;
        valid_s[d] = 1'b1;
        while (!took && n < 400) begin
            @(posedge clk);
            took = ready_w[d];
            @(negedge clk);
            n++;
        end
        valid_s[d] = 1'b0;
        acc = cyc;
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut %0d char %0h: not accepted within 400 cycles", d, c);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", 32'(n < 1000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] keys[10] = '{8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h7A, 8'h43, 8'h44, 8'h45, 8'h46};

    initial begin
        int acc;
        int acc2;
        int nacc;
        valid_s[0] = 1'b0; valid_s[1] = 1'b0;
        data_s[0] = 8'd0;  data_s[1] = 8'd0;

        #12;
        chk("rst_tone", 32'(tone_w[0]), 32'd0);
        chk("rst_active", 32'(active_w[0]), 32'd0);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_ready", 32'(ready_w[0]), 32'd1);
        chk("rst_addr", 32'(addr_w[0]), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mapped key 'C'
        send(0, 8'h43, acc);
        wait_cyc(acc + 1);
        chk("c_addr", 32'(addr_w[0]), 32'h43);
        chk("c_lookup_silent", 32'(tone_w[0]), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            wait_cyc(acc + k);
            chk("c_tone", 32'(tone_w[0]), 32'd758432);
            chk("c_active", 32'(active_w[0]), 32'd1);
        end
        wait_cyc(acc + 6);
        chk("c_gap_tone", 32'(tone_w[0]), 32'd0);
        chk("c_gap_busy", 32'(busy_w[0]), 32'd1);
        wait_cyc(acc + 8);
        chk("c_done_busy", 32'(busy_w[0]), 32'd0);
        drain();

        // Unmapped key 'A'
        send(0, 8'h41, acc);
        chk("a_busy0", 32'(busy_w[0]), 32'd1);
        wait_cyc(acc + 1);
        chk("a_addr", 32'(addr_w[0]), 32'h41);
        chk("a_busy1", 32'(busy_w[0]), 32'd1);
        chk("a_tone", 32'(tone_w[0]), 32'd0);
        wait_cyc(acc + 2);
        chk("a_busy2", 32'(busy_w[0]), 32'd0);
        chk("a_active", 32'(active_w[0]), 32'd0);
        drain();

        // 'z' then unmapped 'a' back to back
        send(0, 8'h7A, acc);
        send(0, 8'h61, acc2);
        for (int k = 2; k <= 5; k++) begin
            wait_cyc(acc + k);
            chk("z_tone", 32'(tone_w[0]), 32'd477781);
        end
        for (int k = 6; k <= 9; k++) begin
            wait_cyc(acc + k);
            chk("z_silent", 32'(tone_w[0]), 32'd0);
        end
        chk("za_addr", 32'(addr_w[0]), 32'h61);
        wait_cyc(acc + 10);
        chk("za_busy", 32'(busy_w[0]), 32'd0);
        chk("za_tone", 32'(tone_w[0]), 32'd0);
        drain();

        // Burst of ten keys while the first one plays
        played.delete();
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            send(0, keys[i], acc);
            nacc++;
            if (nacc == ACC_FULL) chk("burst_ready_low", 32'(ready_w[0]), 32'd0);
        end
        drain();
        chk("burst_count", 32'(played.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < played.size()) chk($sformatf("burst_note%0d", i), 32'(played[i]), 32'(rom_lookup(keys[i])));
        end

        // Reset in the middle of a note
        send(0, 8'h43, acc);
        wait_cyc(acc + 3);
        chk("mid_tone_before", 32'(tone_w[0]), 32'd758432);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tone", 32'(tone_w[0]), 32'd0);
        chk("mid_rst_active", 32'(active_w[0]), 32'd0);
        chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        chk("mid_rst_ready", 32'(ready_w[0]), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        played.delete();
        acc2 = cyc;
        wait_cyc(acc2 + 12);
        chk("post_rst_notes", 32'(played.size()), 32'd0);
        chk("post_rst_busy", 32'(busy_w[0]), 32'd0);

        // No-gap instance: 'C' then 'z'
        send(1, 8'h43, acc);
        send(1, 8'h7A, acc2);
        for (int k = 2; k <= 5; k++) begin
            wait_cyc(acc + k);
            chk("ng_c_tone", 32'(tone_w[1]), 32'd758432);
        end
        wait_cyc(acc + 6);
        chk("ng_idle_tone", 32'(tone_w[1]), 32'd0);
        wait_cyc(acc + 7);
        chk("ng_lookup_tone", 32'(tone_w[1]), 32'd0);
        chk("ng_lookup_addr", 32'(addr_w[1]), 32'h7A);
        for (int k = 8; k <= 11; k++) begin
            wait_cyc(acc + k);
            chk("ng_z_tone", 32'(tone_w[1]), 32'd477781);
        end
        wait_cyc(acc + 12);
        chk("ng_end_tone", 32'(tone_w[1]), 32'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
